// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and state encoding for the UART receiver.
// Optional parity state is present only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the serial line, resets to 1 (idle).
// Ports: clk, rst_n (async, active-low), d (async input), q (synchronized).
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling 8N1 receiver (8E1 with UART_RX_PARITY_EN).
// Ports: clk, rst_n, rx in; data_out, valid, framing_err, busy out.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       framing_err,
  output logic       busy
);

  localparam int OS_DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int OS_DIV = (OS_DIV_RAW < 1) ? 1 : OS_DIV_RAW;
  localparam int DIV_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OS_DIV - 1);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_MID  = 4'(MID_SAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  logic rx_s;

  state_e state_q, state_d;

  logic [DIV_W-1:0]     div_q;
  logic [3:0]           tick_cnt_q;
  logic [2:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [7:0]           data_q;
  logic                 valid_q;
  logic                 ferr_q;

  logic tick;
  logic mid_tick;
  logic last_tick;
  logic do_shift;
  logic good;
  logic bad;
  logic par_ok;
  logic frame_start;
  logic state_chg;

`ifdef UART_RX_PARITY_EN
  logic par_err_q;
  logic par_sample;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign tick      = (div_q == DIV_LAST);
  assign mid_tick  = tick && (tick_cnt_q == TICK_MID);
  assign last_tick = tick && (tick_cnt_q == TICK_LAST);

`ifdef UART_RX_PARITY_EN
  assign par_ok = !par_err_q;
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    do_shift = 1'b0;
    good     = 1'b0;
    bad      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        // Mid start bit: still low means a real frame.
        if (mid_tick) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (last_tick) begin
          do_shift = 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (last_tick) begin
          par_sample = 1'b1;
          state_d    = STOP;
        end
      end
`endif
      STOP: begin
        if (last_tick) begin
          if (rx_s && par_ok) begin
            good    = 1'b1;
            state_d = IDLE;
          end else begin
            bad     = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line idles so a break is not reframed.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_start = (state_q == IDLE) && (state_d == START);
  assign state_chg   = (state_d != state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Divider restarts on the start edge so ticks align to it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (frame_start || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else if (state_chg) begin
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      if (tick)     tick_cnt_q <= tick_cnt_q + 4'd1;
      if (do_shift) bit_cnt_q  <= bit_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else if (do_shift) begin
      shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits xor parity bit must be zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (frame_start) begin
      par_err_q <= 1'b0;
    end else if (par_sample) begin
      par_err_q <= (^shift_q) ^ rx_s;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= good;
      ferr_q  <= bad;
      if (good) data_q <= shift_q;
    end
  end

  assign data_out    = data_q;
  assign valid       = valid_q;
  assign framing_err = ferr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx.
// Frame outcomes are predicted from bit values and compared to pulses.
module tb_uart_rx;

  localparam int CLK_FREQ  = 614400;
  localparam int BAUD_RATE = 9600;
  localparam int OS_DIV    = CLK_FREQ / (BAUD_RATE * 16);
  localparam int BIT       = 16 * OS_DIV;
  localparam int GLITCH    = 5 * OS_DIV;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       framing_err;
  logic       busy;

  int n_checks;
  int n_fail;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [7:0] last_good;

  int both_cnt;
  int wide_cnt;
  logic prev_v;
  logic prev_f;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .data_out    (data_out),
    .valid       (valid),
    .framing_err (framing_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) got_q.push_back({1'b0, data_out});
      if (framing_err) got_q.push_back(9'h100);
      if (valid && framing_err) both_cnt++;
      if ((valid && prev_v) || (framing_err && prev_f)) wide_cnt++;
    end
    prev_v = valid;
    prev_f = framing_err;
  end

  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * BIT) @(negedge clk);
  endtask

  // Drives one frame and records the outcome the line rules predict.
  task automatic send_frame(input logic [7:0] b, input bit stop,
                            input bit pflip);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ pflip;
    repeat (BIT) @(negedge clk);
`endif
    rx = stop;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    if (stop && !(PAR_ON && pflip)) begin
      exp_q.push_back({1'b0, b});
      last_good = b;
    end else begin
      exp_q.push_back(9'h100);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({data_out, valid, framing_err, busy} !== 11'h000) begin
      $display("FAIL reset_out: got %h required 000",
               {data_out, valid, framing_err, busy});
      n_fail++;
    end
    rst_n = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || got_q.size() != 0) begin
      $display("FAIL reset_release: busy %b events %0d required 0 0",
               busy, got_q.size());
      n_fail++;
    end
  endtask

  task automatic test_single;
    exp_q.delete();
    got_q.delete();
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(1);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 9'h0A5) begin
      $display("FAIL single_a5: events %0d first %h required 1 0a5",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h1ff);
      n_fail++;
    end
    n_checks++;
    if (data_out !== 8'hA5) begin
      $display("FAIL single_hold: got %h required a5", data_out);
      n_fail++;
    end
  endtask

  task automatic test_glitch;
    got_q.delete();
    rx = 1'b0;
    repeat (GLITCH) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      $display("FAIL glitch_busy: got %b required 1", busy);
      n_fail++;
    end
    rx = 1'b1;
    repeat (10 * OS_DIV) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || got_q.size() != 0) begin
      $display("FAIL glitch_abort: busy %b events %0d required 0 0",
               busy, got_q.size());
      n_fail++;
    end
  endtask

  task automatic test_framing;
    exp_q.delete();
    got_q.delete();
    send_frame(8'h3C, 1'b0, 1'b0);
    n_checks++;
    if (data_out !== last_good) begin
      $display("FAIL framing_hold: got %h required %h",
               data_out, last_good);
      n_fail++;
    end
    idle(1);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 9'h100) begin
      $display("FAIL framing_pulse: events %0d first %h required 1 100",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h1ff);
      n_fail++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      $display("FAIL framing_idle: busy %b required 0", busy);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back;
    exp_q.delete();
    got_q.delete();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(1);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      $display("FAIL b2b_count: got %0d required %0d",
               got_q.size(), exp_q.size());
      n_fail++;
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL b2b_event%0d: got %h required %h",
                 i, got_q[i], exp_q[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    b = 8'h81;
    exp_q.delete();
    got_q.delete();
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = b[4];
    repeat (BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({data_out, valid, framing_err, busy} !== 11'h000) begin
      $display("FAIL midrst_out: got %h required 000",
               {data_out, valid, framing_err, busy});
      n_fail++;
    end
    last_good = 8'h00;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    n_checks++;
    if (got_q.size() != 0 || data_out !== 8'h00) begin
      $display("FAIL midrst_quiet: events %0d data %h required 0 00",
               got_q.size(), data_out);
      n_fail++;
    end
    send_frame(b, 1'b1, 1'b0);
    idle(1);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 9'h081) begin
      $display("FAIL midrst_next: events %0d first %h required 1 081",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h1ff);
      n_fail++;
    end
  endtask

  task automatic test_random;
    logic [7:0] b;
    bit st;
    bit pf;
    exp_q.delete();
    got_q.delete();
    for (int k = 0; k < 10; k++) begin
      b  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      pf = ($urandom_range(0, 3) == 0);
      send_frame(b, st, pf);
      if (!st || (PAR_ON && pf)) idle(1);
      else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      $display("FAIL rand_count: got %0d required %0d",
               got_q.size(), exp_q.size());
      n_fail++;
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL rand_event%0d: got %h required %h",
                 i, got_q[i], exp_q[i]);
        n_fail++;
      end
    end
    n_checks++;
    if (data_out !== last_good) begin
      $display("FAIL rand_hold: got %h required %h", data_out, last_good);
      n_fail++;
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    exp_q.delete();
    got_q.delete();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(1);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(1);
    n_checks++;
    if (got_q.size() != 2 || got_q[0] !== 9'h100 || got_q[1] !== 9'h007)
    begin
      $display("FAIL parity: events %0d required 2 (100 then 007)",
               got_q.size());
      n_fail++;
    end
    n_checks++;
    if (data_out !== 8'h07) begin
      $display("FAIL parity_data: got %h required 07", data_out);
      n_fail++;
    end
  endtask
`endif

  task automatic test_pulse_shape;
    n_checks++;
    if (both_cnt != 0 || wide_cnt != 0) begin
      $display("FAIL pulse_shape: overlap %0d wide %0d required 0 0",
               both_cnt, wide_cnt);
      n_fail++;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    both_cnt  = 0;
    wide_cnt  = 0;
    prev_v    = 1'b0;
    prev_f    = 1'b0;
    last_good = 8'h00;
    rx        = 1'b1;
    rst_n     = 1'b0;
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_pulse_shape();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
